btn_event_ctrl: RTL and testbench
=================================

Name: btn_event_ctrl

Overview:
- Multi-channel push-button front end for the FPGA cache-test bench.
- Synchronises and debounces NBTN raw button inputs against one shared sample-tick prescaler.
- Queues press/release events per channel and delivers them one at a time over a valid/ready port.
- A round-robin scheduler shares the single event port between channels so no channel starves.

Parameters:
- NBTN, 4, number of button channels (2..8)
- IDXW, 2, width of channel index; must satisfy 2**IDXW >= NBTN
- TICKW, 17, prescaler counter width
- TICK_DIV, 65536, clk_i cycles per sample tick (>= 2, <= 2**TICKW)
- STABLE, 4, consecutive differing samples needed to flip a level (1..15)

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- btn_i  in  NBTN  raw asynchronous button inputs
- level_o  out  NBTN  debounced levels
- evt_valid_o  out  1  event available
- evt_ready_i  in  1  consumer accepts event
- evt_idx_o  out  IDXW  channel of the event
- evt_press_o  out  1  1 = press (0->1), 0 = release (1->0)
- overflow_o  out  1  sticky flag: a pending event was overwritten
- clr_ovf_i  in  1  clears overflow_o

Behaviour:
- Interface: one clock, clk_i. Reset rst_ni is asynchronous and active-low. All flops clear immediately on rst_ni=0, including mid-handshake.
- Reset values: level_o=0, evt_valid_o=0, evt_idx_o=0, evt_press_o=0, overflow_o=0. Prescaler, stable counters, pending bits and the RR pointer are also 0.
- Synchroniser:
  - Each btn_i bit passes through 2 flops, giving sync[i].
  - No other logic samples btn_i directly.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for one cycle when count==TICK_DIV-1.
- Per channel, evaluated only on tick:
  - If sync==level: cnt<=0.
  - Otherwise, if cnt==STABLE-1: level<=sync, cnt<=0, and a pending event is raised with type=sync.
  - Otherwise: cnt<=cnt+1.
  - cnt is 4 bits wide. Between ticks all channel state holds.
- Pending store: one pend bit and one type bit per channel.
  - Event raised while pend=1 and the channel is not being loaded into the output that cycle: type overwritten with the newest value, overflow_o<=1.
  - Event raised in the same cycle the channel is loaded into the output: pend stays 1 with the new type. No overflow.
- Output slot FSM, states EMPTY and FULL:
  - EMPTY: if any pend is set, load the round-robin winner, clear its pend, and go to FULL.
  - FULL: if evt_ready_i=1, pop the slot. In the same cycle, load the next winner if any pend remains (stay FULL); otherwise go to EMPTY.
  - evt_valid_o = (state==FULL).
  - evt_idx_o and evt_press_o are held stable while evt_valid_o=1 and evt_ready_i=0.
- Latency: event visible on evt_valid_o exactly 1 cycle after the level_o flip, when the slot is EMPTY.
- Round-robin:
  - Search starts at (last granted index + 1) mod NBTN.
  - The pointer updates only on a load.
  - After reset the search starts at 0.
- overflow_o: set has priority over clr_ovf_i in the same cycle.
- evt_ready_i while EMPTY is ignored.

Decomposition:
- Shared package btn_pkg holds:
  - the state enum {EMPTY, FULL};
  - the localparam for cnt width (4);
  - a rr_next function (next set bit at or after a start index, with wrap).
- One natural sub-module: btn_chan, instanced NBTN times.
  - Contains the 2-flop synchroniser, stable counter and level flop.
  - Outputs level and a one-cycle evt strobe with its type.
- The top level contains the prescaler, the pending store, the round-robin scheduler and the output FSM.

Test Plan (TICK_DIV=4, STABLE=3, NBTN=4):
- Reset: drive btn_i=4'hF and pulse rst_ni low mid-run -> all outputs 0 during reset. No event appears within 2 cycles of release.
- Clean press: btn_i[1] rises and is held -> level_o[1]=1 on the 3rd tick after sync. Next cycle evt_valid_o=1, evt_idx_o=1, evt_press_o=1. With ready=1 the event clears after 1 cycle.
- Glitch rejection: btn_i[0] high for 2 ticks (8 clk), then low -> level_o[0] stays 0 and no event is produced.
- Simultaneous press on ch0 and ch2 in the same tick, evt_ready_i held 0 for 10 cycles -> idx=0 is held stable the whole time. On ready, idx=2 appears next cycle (back-to-back, valid never drops).
- Fairness: ch0 toggling continuously while ch3 presses once -> ch3 is granted before ch0's second grant.
- Overflow: ch3 press then release with ready held 0 and another event occupying the slot -> overflow_o=1 and a single ch3 event with press=0 is delivered. clr_ovf_i=1 then clears overflow_o; if asserted in the same cycle as a new overwrite, overflow_o stays 1.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button event controller.
package btn_pkg;

    localparam int unsigned CNTW   = 4;
    localparam int unsigned RRW    = 4;
    localparam int unsigned RR_MAX = 16;
    localparam int unsigned MAX_CH = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // First set request at or after start, wrapping within n channels.
    function automatic logic [RRW-1:0] rr_next(
        input logic [RR_MAX-1:0] req,
        input logic [RRW-1:0]    start,
        input logic [RRW-1:0]    n
    );
        logic [RRW-1:0] res;
        logic [RRW-1:0] idx;
        logic           found;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_CH; i++) begin
            idx = start + RRW'(i);
            if (idx >= n) idx = idx - n;
            if ((RRW'(i) < n) && !found && req[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchroniser, tick-qualified stable counter and
// debounced level, with a same-cycle event strobe on each level flip.
module btn_chan
    import btn_pkg::*;
#(
    parameter int unsigned STABLE = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_level,
    output logic o_evt_c,
    output logic o_type_c
);

    logic            r_meta;
    logic            r_sync;
    logic            r_level;
    logic [CNTW-1:0] r_cnt;
    logic            w_diff;
    logic            w_done;

    assign w_diff   = r_sync ^ r_level;
    assign w_done   = (r_cnt == CNTW'(STABLE - 1));
    assign o_evt_c  = i_tick & w_diff & w_done;
    assign o_type_c = r_sync;
    assign o_level  = r_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            if (i_tick) begin
                if (!w_diff) begin
                    r_cnt <= '0;
                end else if (w_done) begin
                    r_level <= r_sync;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNTW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/btn_event_ctrl.sv
// Multi-channel button front end: shared prescaler, per-channel debounce,
// pending-event store and a round-robin fed single-entry output slot.
module btn_event_ctrl
    import btn_pkg::*;
#(
    parameter int unsigned NBTN     = 4,
    parameter int unsigned IDXW     = 2,
    parameter int unsigned TICKW    = 17,
    parameter int unsigned TICK_DIV = 65536,
    parameter int unsigned STABLE   = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NBTN-1:0] btn_i,
    output logic [NBTN-1:0] level_o,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic [IDXW-1:0] evt_idx_o,
    output logic            evt_press_o,
    output logic            overflow_o,
    input  logic            clr_ovf_i
);

    logic [TICKW-1:0]  r_presc;
    logic              w_tick;
    logic [NBTN-1:0]   w_evt;
    logic [NBTN-1:0]   w_type;
    logic [NBTN-1:0]   r_pend;
    logic [NBTN-1:0]   r_ptype;
    logic [NBTN-1:0]   w_grant;
    logic [RR_MAX-1:0] w_req;
    logic [RR_MAX-1:0] w_types;
    logic [RRW-1:0]    w_win;
    logic [RRW-1:0]    w_win_next;
    logic [RRW-1:0]    r_rr_ptr;
    logic              w_load;
    logic              w_ovf_set;
    state_e            r_state;
    logic [IDXW-1:0]   r_idx;
    logic              r_press;
    logic              r_ovf;

    assign w_tick      = (r_presc == TICKW'(TICK_DIV - 1));
    assign evt_valid_o = (r_state == FULL);
    assign evt_idx_o   = r_idx;
    assign evt_press_o = r_press;
    assign overflow_o  = r_ovf;

    for (genvar g = 0; g < NBTN; g++) begin : g_chan
        btn_chan #(
            .STABLE (STABLE)
        ) u_chan (
            .i_clk    (clk_i),
            .i_rst_n  (rst_ni),
            .i_tick   (w_tick),
            .i_btn    (btn_i[g]),
            .o_level  (level_o[g]),
            .o_evt_c  (w_evt[g]),
            .o_type_c (w_type[g])
        );
    end

    // Arbitration: the slot accepts a new event when empty or being popped.
    always_comb begin
        w_req      = RR_MAX'(r_pend);
        w_types    = RR_MAX'(r_ptype);
        w_win      = rr_next(w_req, r_rr_ptr, RRW'(NBTN));
        w_win_next = (w_win == RRW'(NBTN - 1)) ? '0 : w_win + RRW'(1);
        w_load     = (|r_pend) && ((r_state == EMPTY) || evt_ready_i);
        w_grant    = '0;
        for (int i = 0; i < NBTN; i++) begin
            if (w_load && (w_win == RRW'(i))) w_grant[i] = 1'b1;
        end
        w_ovf_set  = |(w_evt & r_pend & ~w_grant);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + TICKW'(1);
        end
    end

    // A fresh event beats a same-cycle grant, so the channel stays pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend  <= '0;
            r_ptype <= '0;
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (w_evt[i]) begin
                    r_pend[i]  <= 1'b1;
                    r_ptype[i] <= w_type[i];
                end else if (w_grant[i]) begin
                    r_pend[i]  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf_i) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= EMPTY;
            r_idx    <= '0;
            r_press  <= 1'b0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_load) begin
                        r_state  <= FULL;
                        r_idx    <= IDXW'(w_win);
                        r_press  <= w_types[w_win];
                        r_rr_ptr <= w_win_next;
                    end
                end
                FULL: begin
                    if (evt_ready_i) begin
                        if (w_load) begin
                            r_idx    <= IDXW'(w_win);
                            r_press  <= w_types[w_win];
                            r_rr_ptr <= w_win_next;
                        end else begin
                            r_state  <= EMPTY;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with an expected-event queue checked on
// every output handshake.
module tb_btn_event_ctrl;

    logic       clk_i;
    logic       rst_ni;
    logic [3:0] btn_i;
    logic [3:0] level_o;
    logic       evt_valid_o;
    logic       evt_ready_i;
    logic [1:0] evt_idx_o;
    logic       evt_press_o;
    logic       overflow_o;
    logic       clr_ovf_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [2:0] exp_q[$];

    btn_event_ctrl #(
        .NBTN     (4),
        .IDXW     (2),
        .TICKW    (17),
        .TICK_DIV (4),
        .STABLE   (3)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .btn_i       (btn_i),
        .level_o     (level_o),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_idx_o   (evt_idx_o),
        .evt_press_o (evt_press_o),
        .overflow_o  (overflow_o),
        .clr_ovf_i   (clr_ovf_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; a handshake seen before the edge is scored after it.
    task automatic step();
        logic       hs;
        logic [2:0] got;
        hs  = evt_valid_o && evt_ready_i;
        got = {evt_idx_o, evt_press_o};
        @(posedge clk_i);
        #1;
        cyc++;
        if (hs) begin
            chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("sb_event", 32'(got), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic wait_all(input logic [3:0] want, input int budget);
        int n;
        n = 0;
        while (level_o !== want && n < budget) begin
            step();
            n++;
        end
        chk("wait_level", 32'(level_o), 32'(want));
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        evt_ready_i = 1'b1;
        while ((exp_q.size() != 0 || evt_valid_o) && n < budget) begin
            step();
            n++;
        end
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_valid", 32'(evt_valid_o), 32'd0);
        evt_ready_i = 1'b0;
    endtask

    initial begin
        int e0;
        int flip_exp;
        int seen;
        int bad;

        rst_ni      = 1'b0;
        btn_i       = 4'h0;
        evt_ready_i = 1'b0;
        clr_ovf_i   = 1'b0;
        #2;
        chk("reset_outs", 32'({level_o, evt_valid_o, evt_idx_o, evt_press_o, overflow_o}), 32'd0);
        step();
        step();
        rst_ni = 1'b1;
        cyc    = 0;
        repeat (3) step();

        // Clean press on ch1 with exact debounce latency.
        e0       = cyc;
        flip_exp = ((e0 + 6) / 4) * 4 + 8;
        btn_i[1] = 1'b1;
        exp_q.push_back({2'd1, 1'b1});
        wait_all(4'b0010, 60);
        chk("press_flip_cycle", 32'(cyc), 32'(flip_exp));
        chk("press_valid_at_flip", 32'(evt_valid_o), 32'd0);
        step();
        chk("press_out", 32'({evt_valid_o, evt_idx_o, evt_press_o}), 32'({1'b1, 2'd1, 1'b1}));
        evt_ready_i = 1'b1;
        step();
        chk("press_cleared", 32'(evt_valid_o), 32'd0);
        evt_ready_i = 1'b0;
        btn_i[1] = 1'b0;
        exp_q.push_back({2'd1, 1'b0});
        wait_all(4'b0000, 60);
        drain(20);

        // Glitch shorter than the stable window must be ignored.
        evt_ready_i = 1'b1;
        seen = 0;
        btn_i[0] = 1'b1;
        repeat (8) begin
            step();
            if (level_o[0] || evt_valid_o) seen++;
        end
        btn_i[0] = 1'b0;
        repeat (20) begin
            step();
            if (level_o[0] || evt_valid_o) seen++;
        end
        chk("glitch_rejected", 32'(seen), 32'd0);
        evt_ready_i = 1'b0;

        // Asynchronous reset while an event sits in the slot.
        btn_i = 4'hF;
        wait_all(4'hF, 60);
        step();
        chk("pre_reset_valid", 32'(evt_valid_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("reset_async", 32'({level_o, evt_valid_o, evt_idx_o, evt_press_o, overflow_o}), 32'd0);
        exp_q.delete();
        step();
        chk("reset_hold", 32'({level_o, evt_valid_o, evt_idx_o, evt_press_o, overflow_o}), 32'd0);
        step();
        rst_ni = 1'b1;
        cyc    = 0;
        step();
        chk("post_reset_1", 32'(evt_valid_o), 32'd0);
        step();
        chk("post_reset_2", 32'(evt_valid_o), 32'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), 1'b1});
        wait_all(4'hF, 60);
        drain(40);
        btn_i = 4'h0;
        for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), 1'b0});
        wait_all(4'h0, 60);
        drain(40);

        // Simultaneous ch0/ch2 press with the consumer stalled.
        btn_i = 4'b0101;
        exp_q.push_back({2'd0, 1'b1});
        exp_q.push_back({2'd2, 1'b1});
        wait_all(4'b0101, 60);
        step();
        chk("sim_first", 32'({evt_valid_o, evt_idx_o, evt_press_o}), 32'({1'b1, 2'd0, 1'b1}));
        bad = 0;
        repeat (10) begin
            step();
            if (!(evt_valid_o && evt_idx_o == 2'd0 && evt_press_o)) bad++;
        end
        chk("sim_hold", 32'(bad), 32'd0);
        evt_ready_i = 1'b1;
        step();
        chk("sim_back_to_back", 32'({evt_valid_o, evt_idx_o}), 32'({1'b1, 2'd2}));
        step();
        chk("sim_empty", 32'(evt_valid_o), 32'd0);
        evt_ready_i = 1'b0;
        btn_i = 4'b0000;
        exp_q.push_back({2'd0, 1'b0});
        exp_q.push_back({2'd2, 1'b0});
        wait_all(4'b0000, 60);
        drain(20);

        // Fairness: ch3 is served before ch0's second event.
        btn_i = 4'b0001;
        exp_q.push_back({2'd0, 1'b1});
        wait_all(4'b0001, 60);
        step();
        btn_i = 4'b1000;
        exp_q.push_back({2'd3, 1'b1});
        exp_q.push_back({2'd0, 1'b0});
        wait_all(4'b1000, 60);
        drain(20);
        chk("fair_no_ovf", 32'(overflow_o), 32'd0);

        // Overflow: ch3 release/press/release collapse into one release.
        btn_i = 4'b1010;
        exp_q.push_back({2'd1, 1'b1});
        wait_all(4'b1010, 60);
        step();
        btn_i = 4'b0010;
        wait_all(4'b0010, 60);
        chk("ovf_first_pend", 32'(overflow_o), 32'd0);
        btn_i = 4'b1010;
        wait_all(4'b1010, 60);
        chk("ovf_set", 32'(overflow_o), 32'd1);
        btn_i = 4'b0010;
        wait_all(4'b0010, 60);
        exp_q.push_back({2'd3, 1'b0});
        drain(20);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);
        clr_ovf_i = 1'b1;
        step();
        clr_ovf_i = 1'b0;
        chk("ovf_cleared", 32'(overflow_o), 32'd0);

        // Overwrite in the same cycle as clear: set wins.
        btn_i = 4'b0000;
        exp_q.push_back({2'd1, 1'b0});
        wait_all(4'b0000, 60);
        step();
        btn_i = 4'b1000;
        wait_all(4'b1000, 60);
        chk("ovf2_first_pend", 32'(overflow_o), 32'd0);
        clr_ovf_i = 1'b1;
        btn_i = 4'b0000;
        wait_all(4'b0000, 60);
        chk("ovf_set_beats_clr", 32'(overflow_o), 32'd1);
        clr_ovf_i = 1'b0;
        step();
        chk("ovf_stays", 32'(overflow_o), 32'd1);
        exp_q.push_back({2'd3, 1'b0});
        drain(20);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
